// File: rtl/operand_fetch.sv
`default_nettype none

// ============================================================================
//  Module      : operand_fetch
//  Description : LC-3 decode / operand-fetch stage in front of the 8x16
//                register file. Holds one instruction, drives the file's two
//                read addresses, then captures the operands and the extended
//                offset into an execute bundle.
//                A pending-write scoreboard stalls RAW/WAW hazards until
//                writeback retires the register.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock           in   1   rising-edge clock
//    reset           in   1   synchronous active-high reset
//    flush           in   1   drop held instruction, scoreboard kept
//    instr_valid     in   1   instruction present
//    instr_ready     out  1   stage accepts an instruction this cycle
//    instr           in   16  LC-3 instruction word
//    rf_address_a/b  out  3   register file read addresses
//    rf_data_a/b     in   W   register file read data (combinational)
//    wb_load         in   1   writeback strobe
//    wb_address      in   3   writeback register
//    out_valid       out  1   execute bundle valid
//    out_ready       in   1   execute accepts bundle
//    out_opcode      out  4   instr[15:12]
//    out_dest        out  3   destination register
//    out_dest_write  out  1   instruction writes out_dest
//    out_operand_a   out  W   source A value, 0 if unused
//    out_operand_b   out  W   source B value or sext(imm5), 0 if unused
//    out_offset      out  W   extended offset, 0 if none
// ============================================================================
module operand_fetch #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [15:0]           instr,
    output logic [2:0]            rf_address_a,
    output logic [2:0]            rf_address_b,
    input  logic [DATA_WIDTH-1:0] rf_data_a,
    input  logic [DATA_WIDTH-1:0] rf_data_b,
    input  logic                  wb_load,
    input  logic [2:0]            wb_address,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_opcode,
    output logic [2:0]            out_dest,
    output logic                  out_dest_write,
    output logic [DATA_WIDTH-1:0] out_operand_a,
    output logic [DATA_WIDTH-1:0] out_operand_b,
    output logic [DATA_WIDTH-1:0] out_offset
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_EMPTY  = 2'd0;
    localparam logic [1:0] c_ST_DECODE = 2'd1;
    localparam logic [1:0] c_ST_VALID  = 2'd2;

    // ------------------------------------------------------------------
    // LC-3 opcodes
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_BR   = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_LD   = 4'b0010;
    localparam logic [3:0] c_OP_ST   = 4'b0011;
    localparam logic [3:0] c_OP_JSR  = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_LDR  = 4'b0110;
    localparam logic [3:0] c_OP_STR  = 4'b0111;
    localparam logic [3:0] c_OP_NOT  = 4'b1001;
    localparam logic [3:0] c_OP_LDI  = 4'b1010;
    localparam logic [3:0] c_OP_STI  = 4'b1011;
    localparam logic [3:0] c_OP_JMP  = 4'b1100;
    localparam logic [3:0] c_OP_LEA  = 4'b1110;
    localparam logic [3:0] c_OP_TRAP = 4'b1111;

    localparam logic [2:0] c_LINK_REG = 3'd7;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [15:0]           r_ir;
    logic [7:0]            r_pending;
    logic [3:0]            r_out_opcode;
    logic [2:0]            r_out_dest;
    logic                  r_out_dest_write;
    logic [DATA_WIDTH-1:0] r_out_operand_a;
    logic [DATA_WIDTH-1:0] r_out_operand_b;
    logic [DATA_WIDTH-1:0] r_out_offset;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [3:0]            w_opcode;
    logic                  w_uses_a;
    logic                  w_uses_b;
    logic                  w_b_imm;
    logic                  w_writes;
    logic [2:0]            w_src_b;
    logic [2:0]            w_dest;
    logic [DATA_WIDTH-1:0] w_offset;
    logic [DATA_WIDTH-1:0] w_sext5;
    logic [DATA_WIDTH-1:0] w_sext6;
    logic [DATA_WIDTH-1:0] w_sext9;
    logic [DATA_WIDTH-1:0] w_sext11;
    logic [DATA_WIDTH-1:0] w_zext8;
    logic [DATA_WIDTH-1:0] w_operand_a;
    logic [DATA_WIDTH-1:0] w_operand_b;
    logic                  w_stall;
    logic                  w_out_valid;
    logic                  w_instr_ready;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_capture;
    logic [1:0]            w_state_next;
    logic [7:0]            w_set_mask;
    logic [7:0]            w_clr_mask;
    logic [7:0]            w_pending_next;

    // ------------------------------------------------------------------
    // Offset / immediate extensions of the held instruction
    // ------------------------------------------------------------------
    assign w_sext5  = {{(DATA_WIDTH-5){r_ir[4]}},   r_ir[4:0]};
    assign w_sext6  = {{(DATA_WIDTH-6){r_ir[5]}},   r_ir[5:0]};
    assign w_sext9  = {{(DATA_WIDTH-9){r_ir[8]}},   r_ir[8:0]};
    assign w_sext11 = {{(DATA_WIDTH-11){r_ir[10]}}, r_ir[10:0]};
    assign w_zext8  = {{(DATA_WIDTH-8){1'b0}},      r_ir[7:0]};

    assign w_opcode = r_ir[15:12];

    // ------------------------------------------------------------------
    // Field decode: which register ports are used, whether the
    // instruction writes a register, and which offset applies.
    // Source A is always IR[8:6] when used; source B is either IR[2:0]
    // (operate instructions) or IR[11:9] (stores).
    // ------------------------------------------------------------------
    always_comb begin
        w_uses_a = 1'b0;
        w_uses_b = 1'b0;
        w_b_imm  = 1'b0;
        w_writes = 1'b0;
        w_src_b  = r_ir[2:0];
        w_dest   = r_ir[11:9];
        w_offset = '0;
        case (w_opcode)
            c_OP_ADD, c_OP_AND: begin
                w_uses_a = 1'b1;
                w_writes = 1'b1;
                if (r_ir[5]) begin
                    w_b_imm = 1'b1;
                end else begin
                    w_uses_b = 1'b1;
                end
            end
            c_OP_NOT: begin
                w_uses_a = 1'b1;
                w_writes = 1'b1;
            end
            c_OP_LD, c_OP_LDI, c_OP_LEA: begin
                w_writes = 1'b1;
                w_offset = w_sext9;
            end
            c_OP_LDR: begin
                w_uses_a = 1'b1;
                w_writes = 1'b1;
                w_offset = w_sext6;
            end
            c_OP_ST, c_OP_STI: begin
                w_uses_b = 1'b1;
                w_src_b  = r_ir[11:9];
                w_offset = w_sext9;
            end
            c_OP_STR: begin
                w_uses_a = 1'b1;
                w_uses_b = 1'b1;
                w_src_b  = r_ir[11:9];
                w_offset = w_sext6;
            end
            c_OP_BR: begin
                w_offset = w_sext9;
            end
            c_OP_JMP: begin
                w_uses_a = 1'b1;
            end
            c_OP_JSR: begin
                w_writes = 1'b1;
                w_dest   = c_LINK_REG;
                if (r_ir[11]) begin
                    w_offset = w_sext11;
                end else begin
                    w_uses_a = 1'b1;
                end
            end
            c_OP_TRAP: begin
                w_writes = 1'b1;
                w_dest   = c_LINK_REG;
                w_offset = w_zext8;
            end
            default: begin
                // RTI and the reserved opcode touch no registers
            end
        endcase
    end

    // Unused ports read R0 so the file address never toggles needlessly
    assign rf_address_a = w_uses_a ? r_ir[8:6] : 3'd0;
    assign rf_address_b = w_uses_b ? w_src_b   : 3'd0;

    assign w_operand_a = w_uses_a ? rf_data_a : '0;
    assign w_operand_b = w_b_imm  ? w_sext5 :
                         w_uses_b ? rf_data_b : '0;

    // Any source or destination with an outstanding write holds the
    // instruction in DECODE. The unused-port addresses are already forced
    // to R0, so the use flags must qualify each term.
    assign w_stall = (w_uses_a & r_pending[rf_address_a]) |
                     (w_uses_b & r_pending[rf_address_b]) |
                     (w_writes & r_pending[w_dest]);

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // A bundle being flushed is withdrawn immediately so execute cannot
    // take it in the flush cycle.
    assign w_out_valid   = (r_state == c_ST_VALID) & ~flush & ~reset;
    assign w_instr_ready = ~reset & ~flush &
                           ((r_state == c_ST_EMPTY) |
                            ((r_state == c_ST_VALID) & out_ready));
    assign w_in_fire     = instr_valid & w_instr_ready;
    assign w_out_fire    = w_out_valid & out_ready;
    assign w_capture     = (r_state == c_ST_DECODE) & ~w_stall & ~flush;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_next = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                if (!w_stall) begin
                    w_state_next = c_ST_VALID;
                end
            end
            c_ST_VALID: begin
                if (w_out_fire) begin
                    w_state_next = w_in_fire ? c_ST_DECODE : c_ST_EMPTY;
                end
            end
            default: begin
                w_state_next = c_ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_next = c_ST_EMPTY;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard update. The set is applied after the clear so that a
    // retire and a new claim on the same register leave it pending.
    // ------------------------------------------------------------------
    assign w_set_mask     = (w_capture & w_writes) ? (8'd1 << w_dest) : 8'd0;
    assign w_clr_mask     = wb_load ? (8'd1 << wb_address) : 8'd0;
    assign w_pending_next = (r_pending & ~w_clr_mask) | w_set_mask;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= c_ST_EMPTY;
            r_ir             <= 16'd0;
            r_pending        <= 8'h00;
            r_out_opcode     <= 4'd0;
            r_out_dest       <= 3'd0;
            r_out_dest_write <= 1'b0;
            r_out_operand_a  <= '0;
            r_out_operand_b  <= '0;
            r_out_offset     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (w_in_fire) begin
                r_ir <= instr;
            end
            if (w_capture) begin
                r_out_opcode     <= w_opcode;
                r_out_dest       <= w_writes ? w_dest : 3'd0;
                r_out_dest_write <= w_writes;
                r_out_operand_a  <= w_operand_a;
                r_out_operand_b  <= w_operand_b;
                r_out_offset     <= w_offset;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr_ready    = w_instr_ready;
    assign out_valid      = w_out_valid;
    assign out_opcode     = r_out_opcode;
    assign out_dest       = r_out_dest;
    assign out_dest_write = r_out_dest_write;
    assign out_operand_a  = r_out_operand_a;
    assign out_operand_b  = r_out_operand_b;
    assign out_offset     = r_out_offset;

endmodule

`default_nettype wire
